// File: rtl/instr_loader.sv
// Program loader: packs a byte stream into 16-bit words and writes them into the core's instruction memory.
// Optional end-of-load checksum byte is enabled by defining CHECKSUM_EN.
module instr_loader #(
   parameter int          ADDR_W   = 8,
   parameter logic [15:0] END_MARK = 16'hFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_load,
   input  logic              abort,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              we,
   output logic [15:0]       instruction,
   output logic [ADDR_W-1:0] instruct_dir,
   output logic              finish,
   output logic              cpu_reset,
   output logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              error
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HI   = 3'd1;
   localparam logic [2:0] ST_LO   = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_CHK  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

   logic [2:0]        state_r;
   logic [2:0]        next_state_s;
   logic [7:0]        hi_r;
   logic [ADDR_W-1:0] addr_r;
   logic [15:0]       word_s;
   logic              accept_s;
   logic              start_s;
   logic              last_s;

`ifdef CHECKSUM_EN
   logic [7:0] sum_r;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      csum_add = acc + b;
   endfunction
`endif

   assign byte_ready = (state_r == ST_HI) || (state_r == ST_LO) || (state_r == ST_CHK);
   assign accept_s   = byte_valid && byte_ready;
   assign word_s     = {hi_r, byte_in};
   assign start_s    = start_load && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign last_s     = (word_count == LAST_CNT);

   // Next-state selection; abort overrides every state.
   always_comb begin
      next_state_s = state_r;
      if (abort) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_load) next_state_s = ST_HI;
               else            next_state_s = state_r;
            end
            ST_HI: begin
               if (accept_s) next_state_s = ST_LO;
               else          next_state_s = state_r;
            end
            ST_LO: begin
               if (!accept_s) begin
                  next_state_s = state_r;
               end else if (word_s == END_MARK) begin
`ifdef CHECKSUM_EN
                  next_state_s = ST_CHK;
`else
                  next_state_s = ST_DONE;
`endif
               end else begin
                  next_state_s = ST_WR;
               end
            end
            ST_WR: begin
               if (last_s) next_state_s = ST_DONE;
               else        next_state_s = ST_HI;
            end
`ifdef CHECKSUM_EN
            ST_CHK: begin
               if (!accept_s)             next_state_s = state_r;
               else if (byte_in == sum_r) next_state_s = ST_DONE;
               else                       next_state_s = ST_IDLE;
            end
`endif
            default: next_state_s = ST_IDLE;
         endcase
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         hi_r         <= 8'h00;
         addr_r       <= '0;
         we           <= 1'b0;
         instruction  <= 16'h0000;
         instruct_dir <= '0;
         finish       <= 1'b0;
         cpu_reset    <= 1'b0;
         word_count   <= '0;
         busy         <= 1'b0;
         error        <= 1'b0;
`ifdef CHECKSUM_EN
         sum_r        <= 8'h00;
`endif
      end else begin
         state_r   <= next_state_s;
         we        <= (next_state_s == ST_WR);
         cpu_reset <= (next_state_s == ST_DONE) && (state_r != ST_DONE);
         busy      <= (next_state_s == ST_HI) || (next_state_s == ST_LO) ||
                      (next_state_s == ST_WR) || (next_state_s == ST_CHK);
         if (abort) begin
            addr_r <= '0;
            finish <= 1'b0;
         end else if (start_s) begin
            addr_r     <= '0;
            word_count <= '0;
            error      <= 1'b0;
            finish     <= 1'b0;
`ifdef CHECKSUM_EN
            sum_r      <= 8'h00;
`endif
         end else begin
            case (state_r)
               ST_HI: begin
                  if (accept_s) begin
                     hi_r <= byte_in;
`ifdef CHECKSUM_EN
                     sum_r <= csum_add(sum_r, byte_in);
`endif
                  end
               end
               ST_LO: begin
                  if (accept_s) begin
`ifdef CHECKSUM_EN
                     sum_r <= csum_add(sum_r, byte_in);
`endif
                     if (word_s != END_MARK) begin
                        instruction  <= word_s;
                        instruct_dir <= addr_r;
                     end
`ifndef CHECKSUM_EN
                     else begin
                        finish <= 1'b1;
                     end
`endif
                  end
               end
               ST_WR: begin
                  // addr_r wraps to 0 only on the final word of a full memory.
                  addr_r     <= addr_r + ADDR_W'(1);
                  word_count <= word_count + (ADDR_W+1)'(1);
                  if (last_s) finish <= 1'b1;
               end
`ifdef CHECKSUM_EN
               ST_CHK: begin
                  if (accept_s) begin
                     if (byte_in == sum_r) finish <= 1'b1;
                     else                  error  <= 1'b1;
                  end
               end
`endif
               default: begin
                  hi_r <= hi_r;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued by the stimulus and checked by a monitor.
module tb_instr_loader;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset;
   logic              start_load;
   logic              abort;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              we;
   logic [15:0]       instruction;
   logic [ADDR_W-1:0] instruct_dir;
   logic              finish;
   logic              cpu_reset;
   logic [ADDR_W:0]   word_count;
   logic              busy;
   logic              error;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int crst_cnt = 0;
   logic [23:0] exp_q[$];

   instr_loader #(.ADDR_W(ADDR_W), .END_MARK(16'hFFFF)) dut (
      .clk(clk), .reset(reset), .start_load(start_load), .abort(abort),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .we(we), .instruction(instruction), .instruct_dir(instruct_dir),
      .finish(finish), .cpu_reset(cpu_reset), .word_count(word_count),
      .busy(busy), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe is matched against the next expected write.
   always @(negedge clk) begin
      if (cpu_reset) crst_cnt++;
      if (we) begin
         logic [23:0] e;
         we_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got %h@%0d expected no write", instruction, instruct_dir);
         end else begin
            e = exp_q.pop_front();
            if ({instruction, instruct_dir} !== e) begin
               errors++;
               $display("FAIL write: got %h@%0d expected %h@%0d", instruction, instruct_dir, e[23:8], e[7:0]);
            end
         end
      end
   end

   task automatic push_wr(input logic [15:0] w, input logic [7:0] a);
      exp_q.push_back({w, a});
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_in = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) chk("byte_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic do_start();
      start_load = 1'b1;
      @(negedge clk);
      start_load = 1'b0;
   endtask

   task automatic wait_finish(input int max);
      int n;
      n = 0;
      while (!finish && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("finish_reached", {31'd0, finish}, 32'd1);
   endtask

   task automatic send_tail(input logic [7:0] csum);
      send_byte(8'hFF);
      send_byte(8'hFF);
`ifdef CHECKSUM_EN
      send_byte(csum);
`else
      if (csum == 8'h00) byte_in = 8'h00;
`endif
   endtask

   initial begin
      int c0;
      int w0;
      logic [15:0] w;
      logic [7:0]  a;
      reset = 1'b0; start_load = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_finish", {31'd0, finish}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, byte_ready}, 32'd0);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      chk("rst_instr", {16'd0, instruction}, 32'd0);
      chk("rst_dir", {24'd0, instruct_dir}, 32'd0);
      chk("rst_wc", {23'd0, word_count}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Basic load: two words then marker.
      c0 = crst_cnt; w0 = we_cnt;
      do_start();
      chk("busy_hi", {31'd0, busy}, 32'd1);
      push_wr(16'h1234, 8'd0);
      push_wr(16'hABCD, 8'd1);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
      send_tail(8'hBC);
      wait_finish(20);
      repeat (3) @(negedge clk);
      chk("basic_finish_held", {31'd0, finish}, 32'd1);
      chk("basic_cpu_reset_cycles", crst_cnt - c0, 32'd1);
      chk("basic_wc", {23'd0, word_count}, 32'd2);
      chk("basic_we_cnt", we_cnt - w0, 32'd2);
      chk("basic_busy", {31'd0, busy}, 32'd0);
      chk("basic_error", {31'd0, error}, 32'd0);

      // Reset asserted mid-LO discards the partial word.
      do_start();
      push_wr(16'h1234, 8'd0);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_we", {31'd0, we}, 32'd0);
      chk("midrst_finish", {31'd0, finish}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ready", {31'd0, byte_ready}, 32'd0);
      chk("midrst_wc", {23'd0, word_count}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Stall between words, with an ignored start_load while busy.
      c0 = crst_cnt; w0 = we_cnt;
      do_start();
      push_wr(16'h1234, 8'd0);
      push_wr(16'hABCD, 8'd1);
      send_byte(8'h12); send_byte(8'h34);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("stall_ready", {31'd0, byte_ready}, 32'd1);
         start_load = (i == 2);
         @(negedge clk);
      end
      start_load = 1'b0;
      send_byte(8'hAB); send_byte(8'hCD);
      send_tail(8'hBC);
      wait_finish(20);
      repeat (2) @(negedge clk);
      chk("stall_we_cnt", we_cnt - w0, 32'd2);
      chk("stall_cpu_reset_cycles", crst_cnt - c0, 32'd1);
      chk("stall_wc", {23'd0, word_count}, 32'd2);

      // Auto-termination after a full memory of words.
      c0 = crst_cnt; w0 = we_cnt;
      do_start();
      for (int i = 0; i < 256; i++) begin
         w = 16'h0100 + 16'(i);
         a = 8'(i);
         push_wr(w, a);
         send_byte(w[15:8]);
         send_byte(w[7:0]);
      end
      wait_finish(10);
      repeat (2) @(negedge clk);
      chk("full_wc", {23'd0, word_count}, 32'd256);
      chk("full_we_cnt", we_cnt - w0, 32'd256);
      chk("full_cpu_reset_cycles", crst_cnt - c0, 32'd1);
      chk("full_busy", {31'd0, busy}, 32'd0);

      // Abort in LO after three words, then a fresh load at address 0.
      w0 = we_cnt;
      do_start();
      for (int i = 0; i < 3; i++) begin
         w = 16'h2000 + 16'(i);
         push_wr(w, 8'(i));
         send_byte(w[15:8]);
         send_byte(w[7:0]);
      end
      send_byte(8'h77);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_finish", {31'd0, finish}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, byte_ready}, 32'd0);
      chk("abort_wc", {23'd0, word_count}, 32'd3);
      chk("abort_we_cnt", we_cnt - w0, 32'd3);
      do_start();
      push_wr(16'h5566, 8'd0);
      send_byte(8'h55); send_byte(8'h66);
      send_tail(8'hB9);
      wait_finish(20);
      chk("after_abort_wc", {23'd0, word_count}, 32'd1);

`ifdef CHECKSUM_EN
      c0 = crst_cnt;
      do_start();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
      send_byte(8'h01);
      wait_finish(20);
      repeat (2) @(negedge clk);
      chk("csum_ok_error", {31'd0, error}, 32'd0);
      chk("csum_ok_cpu_reset", crst_cnt - c0, 32'd1);
      c0 = crst_cnt;
      do_start();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
      send_byte(8'h00);
      repeat (3) @(negedge clk);
      chk("csum_bad_error", {31'd0, error}, 32'd1);
      chk("csum_bad_finish", {31'd0, finish}, 32'd0);
      chk("csum_bad_cpu_reset", crst_cnt - c0, 32'd0);
      chk("csum_bad_busy", {31'd0, busy}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
